// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
// Owns the single-port pixel frame-buffer RAM and shares it between the
// decoder write stream and the display scan-out read port. Reads have
// priority. A pending write is forced through after MAX_STARVE consecutive
// lost cycles, so the decoder always makes progress. The write side walks a
// write pointer across one frame, framed by frame_start / frame_done.
module frame_buffer_arbiter #(
    parameter int DATA_W       = 3,
    parameter int ADDR_W       = 15,
    parameter int FRAME_PIXELS = 19200,
    parameter int RAM_LATENCY  = 1,
    parameter int MAX_STARVE   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              frame_done
);

    // One stage for the RAM-issue cycle plus one per cycle of RAM latency.
    localparam int PIPE_D   = RAM_LATENCY + 1;
    localparam int STARVE_W = $clog2(MAX_STARVE + 1);

    localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
    // One extra bit so a frame that fills the whole address space still
    // compares correctly.
    localparam logic [ADDR_W:0]     FRAME_LIM  = (ADDR_W + 1)'(FRAME_PIXELS);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                frame_done_q, frame_done_d;

    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Read-return pipeline: a valid flag and an in-range flag per stage.
    logic [PIPE_D-1:0]   rd_pipe_vld_q, rd_pipe_vld_d;
    logic [PIPE_D-1:0]   rd_pipe_inr_q, rd_pipe_inr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic in_fill;
    logic wr_cand;
    logic force_wr;
    logic rd_win;
    logic wr_acc;
    logic rd_acc;
    logic rd_in_range;

    // Per-cycle arbitration of the single RAM slot.
    always_comb begin
        in_fill     = (state_q == FILL);
        wr_cand     = in_fill & pixel_valid & ~frame_start;
        force_wr    = wr_cand & (starve_cnt_q == STARVE_MAX);
        rd_win      = rd_req & ~force_wr;
        rd_ready    = rd_win & ~rst;
        pixel_ready = in_fill & ~frame_start & ~rd_win & ~rst;
        wr_acc      = pixel_valid & pixel_ready;
        rd_acc      = rd_req & rd_ready;
        rd_in_range = ({1'b0, rd_addr} < FRAME_LIM);
    end

    // Frame sequencing: next state, write pointer and done pulse.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        // The done pulse is the registered image of the DONE state, so it
        // lands the cycle after the final RAM write.
        frame_done_d = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                end
            end
            FILL: begin
                if (frame_start) begin
                    wr_ptr_d = '0;
                end else if (wr_acc) begin
                    if (wr_ptr_q == LAST_ADDR) begin
                        state_d  = DONE;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (frame_start) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_ptr_d = '0;
            end
        endcase
    end

    // Starvation counter: counts consecutive cycles a ready write lost to a read.
    always_comb begin
        starve_cnt_d = '0;
        if (wr_cand && rd_win) begin
            if (starve_cnt_q == STARVE_MAX) begin
                starve_cnt_d = STARVE_MAX;
            end else begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
        end
    end

    // RAM command for the next cycle; address and data hold when idle.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (wr_acc) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = pixel_data;
        end else if (rd_acc && rd_in_range) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
        end
    end

    // Read pipeline shift: stage 0 is the accept, later stages track latency.
    assign rd_pipe_vld_d[0] = rd_acc;
    assign rd_pipe_inr_d[0] = rd_in_range;

    genvar gi;
    generate
        for (gi = 1; gi < PIPE_D; gi++) begin : g_rd_pipe
            assign rd_pipe_vld_d[gi] = rd_pipe_vld_q[gi-1];
            assign rd_pipe_inr_d[gi] = rd_pipe_inr_q[gi-1];
        end
    endgenerate

    // Read return: capture RAM data, or zero for out-of-range requests.
    always_comb begin
        rd_valid_d = rd_pipe_vld_q[PIPE_D-1];
        rd_data_d  = rd_data_q;
        if (rd_pipe_vld_q[PIPE_D-1]) begin
            rd_data_d = rd_pipe_inr_q[PIPE_D-1] ? mem_rdata : '0;
        end
    end

    // All state and registered outputs; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            starve_cnt_q  <= '0;
            frame_done_q  <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_pipe_vld_q <= '0;
            rd_pipe_inr_q <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            starve_cnt_q  <= starve_cnt_d;
            frame_done_q  <= frame_done_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_pipe_vld_q <= rd_pipe_vld_d;
            rd_pipe_inr_q <= rd_pipe_inr_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign wr_ptr     = wr_ptr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter: a table of per-cycle vectors followed
// by hand-written multi-cycle sequences (full frame, restart, starvation,
// reset with reads in flight). A behavioural single-port RAM with one cycle
// of read latency is attached to the memory port.
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;

    localparam int DW = 3;
    localparam int AW = 15;
    localparam int FP = 19200;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic [DW-1:0] pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] wr_ptr;
    logic          frame_done;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    frame_buffer_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP), .RAM_LATENCY(1), .MAX_STARVE(4)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_ptr(wr_ptr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          fs, pv;
        logic [DW-1:0] pd;
        logic          rq;
        logic [AW-1:0] ra;
        logic          e_pr, e_rr, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [AW-1:0] e_wp;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(int fs, int pv, int pd, int rq, int ra,
                                int pr, int rr, int en, int we, int addr,
                                int wd, int wp, int rv, int rd);
        vec_t v;
        v.fs = fs[0]; v.pv = pv[0]; v.pd = pd[DW-1:0]; v.rq = rq[0]; v.ra = ra[AW-1:0];
        v.e_pr = pr[0]; v.e_rr = rr[0]; v.e_en = en[0]; v.e_we = we[0];
        v.e_addr = addr[AW-1:0]; v.e_wd = wd[DW-1:0]; v.e_wp = wp[AW-1:0];
        v.e_rv = rv[0]; v.e_rd = rd[DW-1:0];
        return v;
    endfunction

    function automatic logic [DW-1:0] pat_b(int i);
        int t;
        t = (i * 5 + 3) % 8;
        return t[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_mem_en"},     32'(mem_en), 0);
        chk({tag, "_mem_we"},     32'(mem_we), 0);
        chk({tag, "_mem_addr"},   32'(mem_addr), 0);
        chk({tag, "_mem_wdata"},  32'(mem_wdata), 0);
        chk({tag, "_rd_valid"},   32'(rd_valid), 0);
        chk({tag, "_rd_data"},    32'(rd_data), 0);
        chk({tag, "_wr_ptr"},     32'(wr_ptr), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        int errs;
        int first_bad;
        int idx;
        int cyc;
        int fd_base;

        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i % 8);

        // fs pv pd rq ra     | pr rr en we addr wd wp rv rd
        vecs[0]  = mk(0,0,0,0,0,      0,0,0,0,0, 0,0,0,0);
        vecs[1]  = mk(0,0,0,1,5,      0,1,1,0,5, 0,0,0,0);
        vecs[2]  = mk(1,1,3,0,0,      0,0,0,0,5, 0,0,0,0);
        vecs[3]  = mk(0,1,6,0,0,      1,0,1,1,0, 6,1,1,5);
        vecs[4]  = mk(0,1,1,1,7,      0,1,1,0,7, 6,1,0,0);
        vecs[5]  = mk(0,1,1,1,8,      0,1,1,0,8, 6,1,0,0);
        vecs[6]  = mk(0,1,1,1,9,      0,1,1,0,9, 6,1,1,7);
        vecs[7]  = mk(0,1,1,1,10,     0,1,1,0,10,6,1,1,0);
        vecs[8]  = mk(0,1,1,1,11,     1,0,1,1,1, 1,2,1,1);
        vecs[9]  = mk(0,0,0,1,12,     0,1,1,0,12,1,2,1,2);
        vecs[10] = mk(0,1,2,0,0,      1,0,1,1,2, 2,3,0,0);
        vecs[11] = mk(0,0,0,0,0,      1,0,0,0,2, 2,3,1,4);
        vecs[12] = mk(0,0,0,1,19200,  0,1,0,0,2, 2,3,0,0);
        vecs[13] = mk(0,0,0,0,0,      1,0,0,0,2, 2,3,0,0);
        vecs[14] = mk(0,0,0,0,0,      1,0,0,0,2, 2,3,1,0);

        // ---- reset ----
        rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
        rd_req = 1'b1; rd_addr = 15'd5;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_ready", 32'(rd_ready), 0);
        chk("rst_pixel_ready", 32'(pixel_ready), 0);
        chk_regs_zero("rst");
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0;

        // ---- table-driven vectors ----
        for (int k = 0; k < NV; k++) begin
            frame_start = vecs[k].fs; pixel_valid = vecs[k].pv; pixel_data = vecs[k].pd;
            rd_req = vecs[k].rq; rd_addr = vecs[k].ra;
            #1;
            chk($sformatf("v%0d_pixel_ready", k), 32'(pixel_ready), 32'(vecs[k].e_pr));
            chk($sformatf("v%0d_rd_ready", k),    32'(rd_ready),    32'(vecs[k].e_rr));
            @(posedge clk); #1;
            chk($sformatf("v%0d_mem_en", k),    32'(mem_en),    32'(vecs[k].e_en));
            chk($sformatf("v%0d_mem_we", k),    32'(mem_we),    32'(vecs[k].e_we));
            chk($sformatf("v%0d_mem_addr", k),  32'(mem_addr),  32'(vecs[k].e_addr));
            chk($sformatf("v%0d_mem_wdata", k), 32'(mem_wdata), 32'(vecs[k].e_wd));
            chk($sformatf("v%0d_wr_ptr", k),    32'(wr_ptr),    32'(vecs[k].e_wp));
            chk($sformatf("v%0d_rd_valid", k),  32'(rd_valid),  32'(vecs[k].e_rv));
            if (vecs[k].e_rv)
                chk($sformatf("v%0d_rd_data", k), 32'(rd_data), 32'(vecs[k].e_rd));
            @(negedge clk);
        end
        frame_start = 1'b0; pixel_valid = 1'b0; rd_req = 1'b0;

        // ---- full frame, writes only ----
        fd_base = fd_count;
        frame_start = 1'b1; pixel_valid = 1'b1; pixel_data = '0;
        @(negedge clk);
        frame_start = 1'b0;
        errs = 0; first_bad = -1;
        for (int i = 0; i < FP; i++) begin
            pixel_data = DW'(i % 8);
            #1;
            if (pixel_ready !== 1'b1) begin errs++; if (first_bad < 0) first_bad = i; end
            @(posedge clk); #1;
            if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === AW'(i) &&
                  mem_wdata === DW'(i % 8))) begin
                errs++; if (first_bad < 0) first_bad = i;
            end
            if (frame_done !== 1'b0) begin errs++; if (first_bad < 0) first_bad = i; end
            @(negedge clk);
        end
        $display("[TB] full frame streamed, first bad index %0d", first_bad);
        chk("fill_seq_errors", 32'(errs), 0);
        #1;
        chk("after_last_pixel_ready", 32'(pixel_ready), 0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(frame_done), 1);
        chk("done_mem_en", 32'(mem_en), 0);
        chk("done_pixel_ready", 32'(pixel_ready), 0);
        chk("done_wr_ptr", 32'(wr_ptr), 0);
        @(posedge clk); #1;
        chk("done_pulse_end", 32'(frame_done), 0);
        chk("idle_pixel_ready", 32'(pixel_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("frame_done_count", 32'(fd_count - fd_base), 1);

        // ---- frame_start restart at wr_ptr==100 ----
        fd_base = fd_count;
        frame_start = 1'b1; pixel_data = 3'd7;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("restart_wr_ptr_before", 32'(wr_ptr), 100);
        frame_start = 1'b1; pixel_data = 3'd5;
        #1;
        chk("restart_pixel_ready", 32'(pixel_ready), 0);
        @(posedge clk); #1;
        chk("restart_mem_en", 32'(mem_en), 0);
        chk("restart_wr_ptr", 32'(wr_ptr), 0);
        @(negedge clk);
        frame_start = 1'b0; pixel_data = 3'd4;
        #1;
        chk("restart_next_ready", 32'(pixel_ready), 1);
        @(posedge clk); #1;
        chk("restart_mem_we", 32'(mem_we), 1);
        chk("restart_mem_addr", 32'(mem_addr), 0);
        chk("restart_mem_wdata", 32'(mem_wdata), 4);
        @(negedge clk);
        chk("restart_no_done", 32'(fd_count - fd_base), 0);

        // ---- starvation guard, then finish the frame and check RAM ----
        pixel_valid = 1'b0;
        fd_base = fd_count;
        frame_start = 1'b1; pixel_valid = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; rd_req = 1'b1; rd_addr = 15'd30000;
        idx = 0; errs = 0;
        for (int c = 0; c < 50; c++) begin
            pixel_data = pat_b(idx);
            #1;
            if (rd_ready !== ((c % 5) != 4)) errs++;
            if (pixel_ready !== ((c % 5) == 4)) errs++;
            if (pixel_ready === 1'b1) idx++;
            @(negedge clk);
        end
        chk("starve_pattern_errors", 32'(errs), 0);
        chk("starve_writes", 32'(idx), 10);
        rd_req = 1'b0;
        cyc = 0;
        while (idx < FP && cyc < 25000) begin
            pixel_data = pat_b(idx);
            #1;
            if (pixel_ready === 1'b1) idx++;
            cyc++;
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        chk("starve_fill_complete", 32'(idx), FP);
        repeat (4) @(negedge clk);
        chk("starve_frame_done", 32'(fd_count - fd_base), 1);
        errs = 0; first_bad = -1;
        for (int i = 0; i < FP; i++) begin
            if (ram[i] !== pat_b(i)) begin errs++; if (first_bad < 0) first_bad = i; end
        end
        $display("[TB] RAM compare done, first bad address %0d", first_bad);
        chk("ram_contents_errors", 32'(errs), 0);

        // ---- reset with two reads in flight, mid-frame ----
        frame_start = 1'b1; pixel_valid = 1'b1; pixel_data = 3'd5;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        pixel_valid = 1'b0; rd_req = 1'b1; rd_addr = 15'd5;
        @(negedge clk);
        rd_addr = 15'd6;
        @(negedge clk);
        rst = 1'b1; pixel_valid = 1'b1;
        #1;
        chk("midrst_rd_ready", 32'(rd_ready), 0);
        chk("midrst_pixel_ready", 32'(pixel_ready), 0);
        @(posedge clk); #1;
        chk_regs_zero("midrst");
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0;
        errs = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (rd_valid !== 1'b0) errs++;
            if (pixel_ready !== 1'b0) errs++;
            @(negedge clk);
        end
        chk("midrst_quiet_errors", 32'(errs), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
